// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of (PC, instruction) pairs.
// Optional same-cycle bypass of an empty queue is enabled by defining IFQ_BYPASS_EN.
module if_id_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ADDR_W-1:0]        in_addr_i,
    input  logic [DATA_W-1:0]        in_inst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_W-1:0]        out_addr_o,
    output logic [DATA_W-1:0]        out_inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_inst;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and in_ready_o depends on registered count only.
    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign in_ready_o = !full;
    assign count_o    = count;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // An empty queue forwards the fetch straight through; it is only stored if decode stalls.
    assign bypass     = empty & in_valid_i & !flush_i;
    assign head_valid = (!empty & !flush_i) | bypass;
    assign head_addr  = empty ? in_addr_i : addr_mem[rd_ptr[IDX_W-1:0]];
    assign head_inst  = empty ? in_inst_i : inst_mem[rd_ptr[IDX_W-1:0]];
    assign push       = in_valid_i & !full & !flush_i & !(bypass & out_ready_i);
    assign pop        = !empty & head_valid & out_ready_i;
`else
    assign head_valid = !empty & !flush_i;
    assign head_addr  = addr_mem[rd_ptr[IDX_W-1:0]];
    assign head_inst  = inst_mem[rd_ptr[IDX_W-1:0]];
    assign push       = in_valid_i & !full & !flush_i;
    assign pop        = head_valid & out_ready_i;
`endif

    assign out_valid_o = head_valid;
    assign out_addr_o  = head_valid ? head_addr : '0;
    assign out_inst_o  = head_valid ? head_inst : NOP_INST;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; outputs are masked whenever nothing valid is presented.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr[IDX_W-1:0]] <= in_addr_i;
            inst_mem[wr_ptr[IDX_W-1:0]] <= in_inst_i;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a reference count model plus a scoreboard of
// expected (PC, instruction) pairs checked whenever decode consumes the head.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_addr = '0;
    logic [31:0]   in_inst = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_addr;
    logic [31:0]   out_inst;
    logic [CW-1:0] count;

    logic [63:0] exp_q[$];
    int tests_run = 0;
    int failures  = 0;
    int m_count   = 0;
    int m_next    = 0;
    bit e_valid;
    bit e_ready;

    if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_addr_i(in_addr), .in_inst_i(in_inst),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_inst_o(out_inst),
        .count_o(count)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA500_0013;
    endfunction

    // Drives one cycle at the falling edge and advances the reference model.
    task automatic drive(input bit v, input logic [31:0] a, input bit r, input bit f);
        bit m_push;
        bit m_pop;
        @(negedge clk);
        m_count   = m_next;
        in_valid  = v;
        in_addr   = a;
        in_inst   = inst_of(a);
        out_ready = r;
        flush     = f;
        e_ready   = (m_count < DEPTH);
`ifdef IFQ_BYPASS_EN
        e_valid   = !f && (m_count > 0 || v);
`else
        e_valid   = !f && (m_count > 0);
`endif
        m_push = v && e_ready && !f;
        m_pop  = e_valid && r;
        if (f) exp_q.delete();
        else if (m_push) exp_q.push_back({a, inst_of(a)});
        m_next = f ? 0 : m_count + int'(m_push) - int'(m_pop);
        #3;
    endtask

    // Scoreboard: every consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        logic [63:0] exp;
        #2;
        if (rst_ni && out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_order: got addr=%h inst=%h, expected no entry", out_addr, out_inst);
            end else begin
                exp = exp_q.pop_front();
                if ({out_addr, out_inst} !== exp) begin
                    failures++;
                    $display("FAIL pop_order: got addr=%h inst=%h, expected addr=%h inst=%h",
                             out_addr, out_inst, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL reset_pre_count: got %0d, expected 3", count);
        end
        #2 rst_ni = 1'b0;
        #1;
        tests_run++;
        if (count !== '0 || out_valid !== 1'b0 || out_inst !== NOP || out_addr !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got count=%0d valid=%b addr=%h inst=%h ready=%b, expected 0 0 0 %h 1",
                     count, out_valid, out_addr, out_inst, in_ready, NOP);
        end
        exp_q.delete();
        m_count = 0;
        m_next  = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (count !== CW'(1) || out_addr !== 32'h80) begin
            failures++;
            $display("FAIL reset_first_push: got count=%0d addr=%h, expected 1 00000080", count, out_addr);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        tests_run++;
        if (count !== CW'(4) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got count=%0d ready=%b, expected 4 0", count, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_addr !== 32'h100 + 32'(4 * i)) begin
                failures++;
                $display("FAIL drain_head: got valid=%b addr=%h, expected 1 %h", out_valid, out_addr, 32'h100 + 32'(4 * i));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (count !== '0 || out_valid !== 1'b0 || out_addr !== '0 || out_inst !== NOP) begin
            failures++;
            $display("FAIL drain_empty: got count=%0d valid=%b addr=%h inst=%h, expected 0 0 0 %h",
                     count, out_valid, out_addr, out_inst, NOP);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            tests_run++;
            if (count !== CW'(m_count) || out_valid !== e_valid) begin
                failures++;
                $display("FAIL stream_state: got count=%0d valid=%b, expected %0d %b", count, out_valid, m_count, e_valid);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (count !== '0) begin
            failures++;
            $display("FAIL stream_drained: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h510, 1'b1, 1'b0);
        tests_run++;
        if (count !== CW'(4) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_same: got count=%0d ready=%b valid=%b, expected 4 0 1", count, in_ready, out_valid);
        end
        drive(1'b1, 32'h510, 1'b0, 1'b0);
        tests_run++;
        if (count !== CW'(3) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_next: got count=%0d ready=%b, expected 3 1", count, in_ready);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (count !== CW'(4)) begin
            failures++;
            $display("FAIL full_pop_refill: got count=%0d, expected 4", count);
        end
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h180 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || out_inst !== NOP) begin
            failures++;
            $display("FAIL flush_same_cycle: got valid=%b inst=%h, expected 0 %h", out_valid, out_inst, NOP);
        end
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tests_run++;
        if (count !== '0 || in_ready !== 1'b1 || out_valid !== e_valid) begin
            failures++;
            $display("FAIL flush_next: got count=%0d ready=%b valid=%b, expected 0 1 %b", count, in_ready, out_valid, e_valid);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (count !== CW'(1) || out_valid !== 1'b1 || out_addr !== 32'h300) begin
            failures++;
            $display("FAIL flush_after_push: got count=%0d valid=%b addr=%h, expected 1 1 00000300", count, out_valid, out_addr);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

`ifdef IFQ_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_addr !== 32'h400 || out_inst !== inst_of(32'h400) || count !== '0) begin
            failures++;
            $display("FAIL bypass: got valid=%b addr=%h count=%0d, expected 1 00000400 0", out_valid, out_addr, count);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (count !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_after: got count=%0d valid=%b, expected 0 0", count, out_valid);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            tests_run++;
            if (count !== CW'(m_count) || in_ready !== e_ready || out_valid !== e_valid) begin
                failures++;
                $display("FAIL random_state: got count=%0d ready=%b valid=%b, expected %0d %b %b",
                         count, in_ready, out_valid, m_count, e_ready, e_valid);
            end
        end
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_entries: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_flush();
`ifdef IFQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between fetch and decode: the successor to the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched (address, instruction) pairs behind a valid/ready handshake on both sides. Back-pressure replaces the stall vector, and a single flush input discards all in-flight fetches. When empty it presents address 0 and the NOP encoding, so decode sees a bubble.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- DEPTH, 4, entry count; power of two, ≥ 2
- NOP_INST, 32'h00000013, value driven on out_inst_o when no valid entry is presented
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush (jump/branch redirect)
- in_valid_i  in  1  fetch presents an entry
- in_ready_o  out  1  queue accepts an entry
- in_addr_i  in  ADDR_W  PC of the fetched instruction
- in_inst_i  in  DATA_W  fetched instruction
- out_valid_o  out  1  head entry valid toward decode
- out_ready_i  in  1  decode consumes the head
- out_addr_o  out  ADDR_W  head PC, 0 when out_valid_o = 0
- out_inst_o  out  DATA_W  head instruction, NOP_INST when out_valid_o = 0
- count_o  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH)+1 bits (extra wrap bit) and a registered count.
- Empty when count = 0; full when count = DEPTH. Pointers wrap modulo DEPTH; the wrap bit toggles on each wrap.
- in_ready_o = !full. This is a function of registered state only, with no combinational path from out_ready_i.
  - A push attempted while full is refused even if a pop occurs in the same cycle.
- Push = in_valid_i & in_ready_o & !flush_i. Writes the entry at wr_ptr, then increments wr_ptr.
- Pop = out_valid_o & out_ready_i. Increments rd_ptr.
- Simultaneous push and pop leaves count unchanged.
- count_o follows push/pop exactly; it never exceeds DEPTH and never underflows.
- out_valid_o = !empty & !flush_i.
- out_addr_o / out_inst_o show the head entry when out_valid_o = 1; otherwise 0 / NOP_INST.
- Flush: with flush_i = 1 at a rising edge, both pointers and count reset to 0. Any push in that cycle is discarded, and no pop is counted.
- Storage array is not reset; outputs are masked whenever out_valid_o = 0.

## Timing
- Reset (rst_ni low, asynchronous) forces:
  - rd_ptr = 0, wr_ptr = 0, count_o = 0
  - in_ready_o = 1, out_valid_o = 0
  - out_addr_o = 0, out_inst_o = NOP_INST
- Reset asserted mid-transfer drops all entries immediately. The first push is accepted on the first edge after rst_ni rises.
- Push-to-out_valid_o latency: 1 cycle in the default build (0 with bypass, see Configuration).
- Throughput: one push and one pop per cycle sustained at any occupancy below full.
- Full with out_ready_i = 1:
  - The pop frees one slot.
  - in_ready_o rises in the next cycle.
  - Exactly one idle input cycle results.
- flush_i deasserts out_valid_o in the same cycle, combinationally. In the next cycle the queue is empty and in_ready_o = 1.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty and in_valid_i = 1 with flush_i = 0, out_valid_o = 1 in the same cycle and out_addr_o / out_inst_o = in_addr_i / in_inst_i.
  - If out_ready_i = 1 in that cycle, the entry is consumed without being written: pointers and count do not change.
  - Otherwise it is written normally.
- IFQ_BYPASS_EN undefined: no input-to-output combinational path. Minimum latency 1 cycle, as above.

## Test plan
- Reset: rst_ni low mid-cycle with 3 entries held → same cycle count_o = 0, out_valid_o = 0, out_inst_o = 32'h00000013, in_ready_o = 1.
- Fill/drain, DEPTH = 4, out_ready_i = 0:
  - Push PCs 0x100, 0x104, 0x108, 0x10C → count_o = 4, in_ready_o = 0.
  - A 5th push at 0x110 is refused.
  - Then out_ready_i = 1 → outputs 0x100..0x10C in order on 4 consecutive cycles.
- Streaming with wrap-around: push and pop every cycle for 20 cycles, PCs 0x0, 0x4, … → count_o is constant at 1 and output order is exact across pointer wrap.
- Full plus simultaneous pop: count_o = 4, in_valid_i = 1, out_ready_i = 1 → pop occurs, push refused, count_o = 3. The push is accepted next cycle and count_o returns to 4.
- Flush: 3 entries held, flush_i = 1 together with a push of 0x200:
  - Same cycle: out_valid_o = 0.
  - Next cycle: count_o = 0 and 0x200 is absent.
  - A following push of 0x300 appears one cycle later.
- Bypass build: empty queue, in_valid_i = 1 with PC 0x400, out_ready_i = 1 → out_valid_o = 1 with out_addr_o = 0x400 in the same cycle, and count_o stays 0.
